// File: rtl/control_pipeline_if.sv
`default_nettype none
// ============================================================================
// Module   : control_pipeline_if
// Brief    : Instruction input plus ID/EX/MEM control bundles of the decode
//            and control-signal pipeline.
// Revision : 1.0
// ============================================================================
interface control_pipeline_if;
    logic [31:0] instruction;

    logic [3:0]  id_alu_op;
    logic [1:0]  id_am;
    logic        id_load, id_mem_write, id_mem_size, id_mem_e;
    logic        id_store_cc, id_b, id_bl, id_rf_e;

    logic [3:0]  ex_alu_op;
    logic [1:0]  ex_am;
    logic        ex_load, ex_mem_write, ex_mem_size, ex_mem_e;
    logic        ex_store_cc, ex_b, ex_bl, ex_rf_e;

    logic        mem_load, mem_mem_write, mem_mem_size, mem_mem_e, mem_rf_e;

    modport master (
        output instruction,
        input  id_alu_op, id_am, id_load, id_mem_write, id_mem_size, id_mem_e,
               id_store_cc, id_b, id_bl, id_rf_e,
               ex_alu_op, ex_am, ex_load, ex_mem_write, ex_mem_size, ex_mem_e,
               ex_store_cc, ex_b, ex_bl, ex_rf_e,
               mem_load, mem_mem_write, mem_mem_size, mem_mem_e, mem_rf_e
    );

    modport slave (
        input  instruction,
        output id_alu_op, id_am, id_load, id_mem_write, id_mem_size, id_mem_e,
               id_store_cc, id_b, id_bl, id_rf_e,
               ex_alu_op, ex_am, ex_load, ex_mem_write, ex_mem_size, ex_mem_e,
               ex_store_cc, ex_b, ex_bl, ex_rf_e,
               mem_load, mem_mem_write, mem_mem_size, mem_mem_e, mem_rf_e
    );
endinterface
`default_nettype wire

// File: rtl/control_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : control_pipeline
// Brief    : ARM-subset instruction decoder feeding ID/EX and EX/MEM control
//            register stages.
// Revision : 1.0
// ============================================================================
module control_pipeline (
    input  wire logic          clk,
    input  wire logic          reset,
    control_pipeline_if.slave  bus
);
    localparam logic [2:0] c_CLS_DP_REG = 3'b000;
    localparam logic [2:0] c_CLS_DP_IMM = 3'b001;
    localparam logic [2:0] c_CLS_LS_IMM = 3'b010;
    localparam logic [2:0] c_CLS_LS_REG = 3'b011;
    localparam logic [2:0] c_CLS_BRANCH = 3'b101;
    localparam logic [3:0] c_ALU_ADD    = 4'b0100;
    localparam logic [3:0] c_ALU_SUB    = 4'b0010;

    logic [31:0] w_ins;
    logic [2:0]  w_class;
    logic [3:0]  w_alu_op;
    logic [1:0]  w_am;
    logic        w_load, w_mem_write, w_mem_size, w_mem_e;
    logic        w_store_cc, w_b, w_bl, w_rf_e;

    assign w_ins   = bus.instruction;
    assign w_class = w_ins[27:25];

    always_comb begin
        w_alu_op    = 4'b0000;
        w_am        = 2'b00;
        w_load      = 1'b0;
        w_mem_write = 1'b0;
        w_mem_size  = 1'b0;
        w_mem_e     = 1'b0;
        w_store_cc  = 1'b0;
        w_b         = 1'b0;
        w_bl        = 1'b0;
        w_rf_e      = 1'b0;
        if (w_ins != 32'd0) begin
            case (w_class)
                c_CLS_DP_REG, c_CLS_DP_IMM: begin
                    w_alu_op   = w_ins[24:21];
                    w_am       = {1'b0, w_class[0]};
                    w_store_cc = w_ins[20];
                    // TST/TEQ/CMP/CMN (1000-1011) only update flags
                    w_rf_e     = (w_ins[24:23] != 2'b10);
                end
                c_CLS_LS_IMM, c_CLS_LS_REG: begin
                    w_mem_e     = 1'b1;
                    w_load      = w_ins[20];
                    w_mem_write = ~w_ins[20];
                    w_rf_e      = w_ins[20];
                    w_mem_size  = w_ins[22];
                    w_alu_op    = w_ins[23] ? c_ALU_ADD : c_ALU_SUB;
                    w_am        = {1'b1, w_class[0]};
                end
                c_CLS_BRANCH: begin
                    w_b      = 1'b1;
                    w_bl     = w_ins[24];
                    w_rf_e   = w_ins[24];
                    w_alu_op = c_ALU_ADD;
                end
                default: ;
            endcase
        end
    end

    assign bus.id_alu_op    = w_alu_op;
    assign bus.id_am        = w_am;
    assign bus.id_load      = w_load;
    assign bus.id_mem_write = w_mem_write;
    assign bus.id_mem_size  = w_mem_size;
    assign bus.id_mem_e     = w_mem_e;
    assign bus.id_store_cc  = w_store_cc;
    assign bus.id_b         = w_b;
    assign bus.id_bl        = w_bl;
    assign bus.id_rf_e      = w_rf_e;

    // ID/EX carries the whole bundle; EX/MEM only the memory/write-back subset
    logic [3:0] r_ex_alu_op;
    logic [1:0] r_ex_am;
    logic       r_ex_load, r_ex_mem_write, r_ex_mem_size, r_ex_mem_e;
    logic       r_ex_store_cc, r_ex_b, r_ex_bl, r_ex_rf_e;
    logic       r_mem_load, r_mem_mem_write, r_mem_mem_size, r_mem_mem_e, r_mem_rf_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_alu_op     <= 4'b0000;
            r_ex_am         <= 2'b00;
            r_ex_load       <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_mem_size   <= 1'b0;
            r_ex_mem_e      <= 1'b0;
            r_ex_store_cc   <= 1'b0;
            r_ex_b          <= 1'b0;
            r_ex_bl         <= 1'b0;
            r_ex_rf_e       <= 1'b0;
            r_mem_load      <= 1'b0;
            r_mem_mem_write <= 1'b0;
            r_mem_mem_size  <= 1'b0;
            r_mem_mem_e     <= 1'b0;
            r_mem_rf_e      <= 1'b0;
        end else begin
            r_ex_alu_op     <= w_alu_op;
            r_ex_am         <= w_am;
            r_ex_load       <= w_load;
            r_ex_mem_write  <= w_mem_write;
            r_ex_mem_size   <= w_mem_size;
            r_ex_mem_e      <= w_mem_e;
            r_ex_store_cc   <= w_store_cc;
            r_ex_b          <= w_b;
            r_ex_bl         <= w_bl;
            r_ex_rf_e       <= w_rf_e;
            r_mem_load      <= r_ex_load;
            r_mem_mem_write <= r_ex_mem_write;
            r_mem_mem_size  <= r_ex_mem_size;
            r_mem_mem_e     <= r_ex_mem_e;
            r_mem_rf_e      <= r_ex_rf_e;
        end
    end

    assign bus.ex_alu_op     = r_ex_alu_op;
    assign bus.ex_am         = r_ex_am;
    assign bus.ex_load       = r_ex_load;
    assign bus.ex_mem_write  = r_ex_mem_write;
    assign bus.ex_mem_size   = r_ex_mem_size;
    assign bus.ex_mem_e      = r_ex_mem_e;
    assign bus.ex_store_cc   = r_ex_store_cc;
    assign bus.ex_b          = r_ex_b;
    assign bus.ex_bl         = r_ex_bl;
    assign bus.ex_rf_e       = r_ex_rf_e;
    assign bus.mem_load      = r_mem_load;
    assign bus.mem_mem_write = r_mem_mem_write;
    assign bus.mem_mem_size  = r_mem_mem_size;
    assign bus.mem_mem_e     = r_mem_mem_e;
    assign bus.mem_rf_e      = r_mem_rf_e;
endmodule
`default_nettype wire

// File: tb/tb_control_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_pipeline
// Brief    : Directed and randomized self-checking bench for control_pipeline.
// Revision : 1.0
// ============================================================================
module tb_control_pipeline;
    logic clk;
    logic reset;
    control_pipeline_if bus ();

    control_pipeline dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Bundle layout: {alu_op[13:10], am[9:8], load, mem_write, mem_size,
    //                 mem_e, store_cc, b, bl, rf_e}
    localparam logic [31:0] c_ADDS = 32'hE2921005;
    localparam logic [31:0] c_CMP  = 32'hE1510002;
    localparam logic [31:0] c_LDR  = 32'hE5921004;
    localparam logic [31:0] c_STRB = 32'hE7421003;
    localparam logic [31:0] c_BL   = 32'hEB000004;
    localparam logic [31:0] c_B    = 32'hEA000004;
    localparam logic [31:0] c_UNS  = 32'hE8000000;

    localparam logic [13:0] c_EXP_ADDS = 14'b0100_01_0000_1001;
    localparam logic [13:0] c_EXP_CMP  = 14'b1010_00_0000_1000;
    localparam logic [13:0] c_EXP_LDR  = 14'b0100_10_1001_0001;
    localparam logic [13:0] c_EXP_STRB = 14'b0010_11_0111_0000;
    localparam logic [13:0] c_EXP_BL   = 14'b0100_00_0000_0111;
    localparam logic [13:0] c_EXP_B    = 14'b0100_00_0000_0100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-class rules
    function automatic logic [13:0] ref_decode(input logic [31:0] ins);
        logic [3:0] alu;
        logic [1:0] am;
        logic ld, mw, ms, me, sc, b, bl, rf;
        int cls;
        int opc;
        alu = 0; am = 0; ld = 0; mw = 0; ms = 0; me = 0; sc = 0; b = 0; bl = 0; rf = 0;
        cls = int'(ins[27:25]);
        opc = int'(ins[24:21]);
        if (ins != 0) begin
            if (cls == 0 || cls == 1) begin
                alu = ins[24:21];
                am  = (cls == 1) ? 2'd1 : 2'd0;
                sc  = ins[20];
                rf  = (opc >= 8 && opc <= 11) ? 1'b0 : 1'b1;
            end else if (cls == 2 || cls == 3) begin
                me  = 1;
                ld  = ins[20];
                mw  = !ins[20];
                rf  = ins[20];
                ms  = ins[22];
                alu = ins[23] ? 4'd4 : 4'd2;
                am  = (cls == 2) ? 2'd2 : 2'd3;
            end else if (cls == 5) begin
                b   = 1;
                bl  = ins[24];
                rf  = ins[24];
                alu = 4'd4;
            end
        end
        return {alu, am, ld, mw, ms, me, sc, b, bl, rf};
    endfunction

    function automatic logic [4:0] mem_subset(input logic [13:0] x);
        return {x[7], x[6], x[5], x[4], x[0]};
    endfunction

    function automatic logic [13:0] obs_id();
        return {bus.id_alu_op, bus.id_am, bus.id_load, bus.id_mem_write, bus.id_mem_size,
                bus.id_mem_e, bus.id_store_cc, bus.id_b, bus.id_bl, bus.id_rf_e};
    endfunction

    function automatic logic [13:0] obs_ex();
        return {bus.ex_alu_op, bus.ex_am, bus.ex_load, bus.ex_mem_write, bus.ex_mem_size,
                bus.ex_mem_e, bus.ex_store_cc, bus.ex_b, bus.ex_bl, bus.ex_rf_e};
    endfunction

    function automatic logic [4:0] obs_mem();
        return {bus.mem_load, bus.mem_mem_write, bus.mem_mem_size, bus.mem_mem_e, bus.mem_rf_e};
    endfunction

    // Expected pipeline contents, advanced once per clock edge
    logic [13:0] exp_ex;
    logic [4:0]  exp_mem;

    task automatic cycle(input logic [31:0] ins, input logic rst, input string tag);
        @(negedge clk);
        bus.instruction = ins;
        reset           = rst;
        #1;
        check({tag, "/id"}, 32'(obs_id()), 32'(ref_decode(ins)));
        @(posedge clk);
        if (rst) begin
            exp_ex  = '0;
            exp_mem = '0;
        end else begin
            exp_mem = mem_subset(exp_ex);
            exp_ex  = ref_decode(ins);
        end
        #1;
        check({tag, "/ex"},  32'(obs_ex()),  32'(exp_ex));
        check({tag, "/mem"}, 32'(obs_mem()), 32'(exp_mem));
    endtask

    task automatic directed_id(input logic [31:0] ins, input logic [13:0] exp, input string tag);
        @(negedge clk);
        bus.instruction = ins;
        #1;
        check(tag, 32'(obs_id()), 32'(exp));
    endtask

    initial begin
        logic [31:0] ins;
        n_tests = 0;
        n_fail  = 0;
        exp_ex  = '0;
        exp_mem = '0;
        bus.instruction = 32'd0;
        reset = 1'b1;

        cycle(32'd0, 1'b1, "reset0");
        cycle(c_LDR, 1'b1, "reset1");
        check("reset_ex_zero", 32'(obs_ex()), 32'd0);
        check("reset_mem_zero", 32'(obs_mem()), 32'd0);

        // Decode spot checks against hand-derived bundles (reset held)
        directed_id(c_ADDS, c_EXP_ADDS, "dec_adds");
        directed_id(c_CMP,  c_EXP_CMP,  "dec_cmp");
        directed_id(c_LDR,  c_EXP_LDR,  "dec_ldr");
        directed_id(c_STRB, c_EXP_STRB, "dec_strb");
        directed_id(c_BL,   c_EXP_BL,   "dec_bl");
        directed_id(c_B,    c_EXP_B,    "dec_b");
        directed_id(32'd0,  14'd0,      "dec_zero");
        directed_id(c_UNS,  14'd0,      "dec_class100");
        directed_id(32'h0C000000, 14'd0, "dec_class110");
        directed_id(32'h0E000000, 14'd0, "dec_class111");

        // Pipeline flow: LDR, ADDS, NOP
        cycle(c_LDR, 1'b0, "pipe_ldr");
        check("pipe_ex_load", 32'(bus.ex_load), 32'd1);
        cycle(c_ADDS, 1'b0, "pipe_adds");
        check("pipe_mem_load", 32'(bus.mem_load), 32'd1);
        check("pipe_mem_rf_e", 32'(bus.mem_rf_e), 32'd1);
        check("pipe_ex_store_cc", 32'(bus.ex_store_cc), 32'd1);
        cycle(32'd0, 1'b0, "pipe_nop0");
        cycle(32'd0, 1'b0, "pipe_nop1");
        check("pipe_ex_drained", 32'(obs_ex()), 32'd0);
        check("pipe_mem_drained", 32'(obs_mem()), 32'd0);

        // Reset mid-stream while LDR is in EX and ADDS is in ID
        cycle(c_LDR, 1'b0, "mid_ldr");
        cycle(c_ADDS, 1'b1, "mid_rst");
        check("mid_ex_zero", 32'(obs_ex()), 32'd0);
        check("mid_mem_zero", 32'(obs_mem()), 32'd0);
        check("mid_id_adds", 32'(obs_id()), 32'(c_EXP_ADDS));

        // Randomized traffic biased toward the supported classes
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 9))
                0:       ins = 32'd0;
                1, 2:    ins[27:25] = 3'b000;
                3:       ins[27:25] = 3'b001;
                4, 5:    ins[27:25] = 3'b010;
                6:       ins[27:25] = 3'b011;
                7:       ins[27:25] = 3'b101;
                default: ;
            endcase
            cycle(ins, ($urandom_range(0, 19) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
